// File: rtl/prism_out_logger.sv
// Timestamped change logger for the PRISM output bus, read back through a TinyQV register window.
// Define PRISM_LOG_MASK_EN to add a per-bit trigger mask register at offset 0x08.
module prism_out_logger #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  mon_data,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        irq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [6:0]      data;
      logic [TS_W-1:0] ts;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic            enable_q, enable_d;
   logic            en_dly_q;
   logic            irq_en_q, irq_en_d;
   logic [3:0]      thr_q, thr_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      drop_q, drop_d;
   logic [TS_W-1:0] ts_q, ts_d;
   logic [6:0]      prev_q, prev_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rd_prev_q;
   logic            irq_q, irq_d;
   logic [6:0]      mask;

   logic wr32, ctrl_wr, flush, rd_act, empty, full, pop, event_hit, push, drop;
   logic unused_bits;

`ifdef PRISM_LOG_MASK_EN
   logic [6:0] mask_q, mask_d;
   assign mask = mask_q;
`else
   assign mask = 7'h7F;
`endif

   assign unused_bits = ^data_in;
   assign data_ready  = 1'b1;
   assign irq         = irq_q;

   assign wr32      = (data_write_n == 2'b10);
   assign ctrl_wr   = wr32 && (address == 6'h00);
   assign flush     = ctrl_wr && data_in[1];
   assign rd_act    = (data_read_n != 2'b11);
   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign pop       = rd_act && !rd_prev_q && (address == 6'h04) && !empty;
   // The first enabled cycle only samples prev, so it can never log an event.
   assign event_hit = enable_q && en_dly_q && (((mon_data ^ prev_q) & mask) != 7'h00);
   assign push      = event_hit && (!full || pop) && !flush;
   assign drop      = event_hit && full && !pop && !flush;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no latch is inferred.
      enable_d   = enable_q;
      irq_en_d   = irq_en_q;
      thr_d      = thr_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      ts_d       = ts_q;
      prev_d     = prev_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
`ifdef PRISM_LOG_MASK_EN
      mask_d     = mask_q;
      if (wr32 && (address == 6'h08)) mask_d = data_in[6:0];
`endif

      if (ctrl_wr) begin
         enable_d = data_in[0];
         irq_en_d = data_in[2];
         thr_d    = data_in[11:8];
      end

      if (ctrl_wr && data_in[0] && !enable_q) ts_d = '0;
      else if (enable_q)                      ts_d = ts_q + 1'b1;

      if (enable_q) prev_d = mon_data;

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_d     = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 1'b1;
         end
      end

      irq_d = irq_en_q && (overflow_q || ((thr_q != 4'h0) && (8'(count_q) >= 8'(thr_q))));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         enable_q   <= 1'b0;
         en_dly_q   <= 1'b0;
         irq_en_q   <= 1'b0;
         thr_q      <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
         ts_q       <= '0;
         prev_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_prev_q  <= 1'b0;
         irq_q      <= 1'b0;
`ifdef PRISM_LOG_MASK_EN
         mask_q     <= 7'h7F;
`endif
      end else begin
         enable_q   <= enable_d;
         en_dly_q   <= enable_q;
         irq_en_q   <= irq_en_d;
         thr_q      <= thr_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         ts_q       <= ts_d;
         prev_q     <= prev_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_prev_q  <= rd_act;
         irq_q      <= irq_d;
`ifdef PRISM_LOG_MASK_EN
         mask_q     <= mask_d;
`endif
      end
   end

   // NOTE: storage is not reset; clearing the pointers and count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{data: mon_data, ts: ts_q};
   end

   always_comb begin
      data_out = '0;
      case (address)
         6'h00: begin
            data_out[31]    = overflow_q;
            data_out[23:16] = drop_q;
            data_out[15:8]  = 8'(count_q);
            data_out[7:4]   = thr_q;
            data_out[2]     = irq_en_q;
            data_out[0]     = enable_q;
         end
         6'h04: begin
            if (!empty) begin
               data_out[31]         = 1'b1;
               data_out[30:24]      = mem_q[rd_ptr_q].data;
               data_out[TS_W-1:0]   = mem_q[rd_ptr_q].ts;
            end
         end
`ifdef PRISM_LOG_MASK_EN
         6'h08:   data_out = {25'b0, mask_q};
`endif
         default: data_out = '0;
      endcase
   end

endmodule

// File: tb/tb_prism_out_logger.sv
// Directed self-checking bench for prism_out_logger (DEPTH=8, TS_W=16).
module tb_prism_out_logger;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  mon_data;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;
   logic        irq;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int en_cyc       = 0;
   int t0, t_new, t11;
   logic [31:0] v;

   prism_out_logger #(.DEPTH(8), .TS_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mon_data     (mon_data),
      .address      (address),
      .data_in      (data_in),
      .data_write_n (data_write_n),
      .data_read_n  (data_read_n),
      .data_out     (data_out),
      .data_ready   (data_ready),
      .irq          (irq)
   );

   always #8 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn = 2'b10);
      address      = a;
      data_in      = d;
      data_write_n = wn;
      tick();
      data_write_n = 2'b11;
   endtask

   task automatic rd(input logic [5:0] a, output logic [31:0] val);
      address     = a;
      data_read_n = 2'b00;
      #1 val = data_out;
      tick();
      data_read_n = 2'b11;
      tick();
   endtask

   function automatic logic [31:0] ent(input logic [6:0] d, input int ts);
      logic [31:0] e;
      e        = '0;
      e[31]    = 1'b1;
      e[30:24] = d;
      e[15:0]  = ts[15:0];
      return e;
   endfunction

   initial begin
      rst_n        = 1'b0;
      mon_data     = 7'h00;
      address      = 6'h00;
      data_in      = '0;
      data_write_n = 2'b11;
      data_read_n  = 2'b11;
      #20;
      check("rst_ctrl", data_out, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_ready", {31'b0, data_ready}, 32'h1);
      address = 6'h04;
      #1 check("rst_data", data_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Narrow writes are ignored.
      wr(6'h00, 32'h1, 2'b00);
      wr(6'h00, 32'h1, 2'b01);
      rd(6'h00, v);
      check("narrow_wr", v, 32'h0);

      // Two changes at ts 10 and 25.
      wr(6'h00, 32'h1);
      en_cyc = cyc;
      repeat (10) tick();
      mon_data = 7'h05;
      repeat (15) tick();
      mon_data = 7'h07;
      tick();
      rd(6'h00, v);
      check("t1_ctrl", v, 32'h0000_0201);
      rd(6'h04, v);
      check("t1_rd0", v, 32'h8500_000A);
      rd(6'h04, v);
      check("t1_rd1", v, 32'h8700_0019);
      rd(6'h04, v);
      check("t1_rd2", v, 32'h0);

      // Overflow: ten changes into an 8-deep FIFO.
      wr(6'h00, 32'h3);
      t0 = cyc - en_cyc;
      for (int i = 0; i < 10; i++) begin
         mon_data = 7'h10 + 7'(i);
         tick();
      end
      tick();
      rd(6'h00, v);
      check("t2_ovf", v, 32'h8002_0801);

      // Full FIFO: change coincides with the first cycle of a pop.
      mon_data    = 7'h2A;
      t_new       = cyc - en_cyc;
      address     = 6'h04;
      data_read_n = 2'b00;
      #1 check("t3_pop_head", data_out, ent(7'h10, t0));
      tick();
      data_read_n = 2'b11;
      tick();
      rd(6'h00, v);
      check("t3_ctrl", v, 32'h8002_0801);
      for (int i = 1; i < 8; i++) begin
         rd(6'h04, v);
         check("t3_drain", v, ent(7'h10 + 7'(i), t0 + i));
      end
      rd(6'h04, v);
      check("t3_newest", v, ent(7'h2A, t_new));

      // Flush clears overflow; irq on threshold 3.
      wr(6'h00, 32'h307);
      rd(6'h00, v);
      check("t2_flush", v, 32'h0000_0035);
      mon_data = 7'h01; tick();
      mon_data = 7'h02; tick();
      mon_data = 7'h03; tick();
      check("t4_irq_lag", {31'b0, irq}, 32'h0);
      tick();
      check("t4_irq_rise", {31'b0, irq}, 32'h1);
      address     = 6'h04;
      data_read_n = 2'b00;
      tick();
      check("t4_irq_hold", {31'b0, irq}, 32'h1);
      data_read_n = 2'b11;
      tick();
      check("t4_irq_fall", {31'b0, irq}, 32'h0);

      // Enable edge with mon_data=0x3F, held read, async reset.
      wr(6'h00, 32'h2);
      mon_data = 7'h3F;
      tick();
      wr(6'h00, 32'h105);
      en_cyc = cyc;
      tick();
      tick();
      rd(6'h00, v);
      check("t5_no_entry", v, 32'h0000_0015);
      mon_data = 7'h11;
      t11      = cyc - en_cyc;
      tick();
      mon_data = 7'h12;
      tick();
      tick();
      address     = 6'h04;
      data_read_n = 2'b00;
      #1 check("t5_hold_head", data_out, ent(7'h11, t11));
      repeat (3) tick();
      data_read_n = 2'b11;
      tick();
      rd(6'h00, v);
      check("t5_one_pop", v, 32'h0000_0115);
      check("t5_irq_pre", {31'b0, irq}, 32'h1);
      mon_data = 7'h13;
      tick();
      #3 rst_n = 1'b0;
      #1;
      check("t5_rst_irq", {31'b0, irq}, 32'h0);
      check("t5_rst_ctrl", data_out, 32'h0);
      rst_n = 1'b1;
      tick();

      // Mask register (or its absence).
      wr(6'h08, 32'h01);
      wr(6'h00, 32'h1);
      tick();
      mon_data = mon_data ^ 7'h08;
      tick();
      tick();
      rd(6'h00, v);
`ifdef PRISM_LOG_MASK_EN
      check("t6_mask_ctrl", v, 32'h0000_0001);
`else
      check("t6_mask_ctrl", v, 32'h0000_0101);
`endif
      rd(6'h08, v);
`ifdef PRISM_LOG_MASK_EN
      check("t6_mask_rd", v, 32'h0000_0001);
`else
      check("t6_mask_rd", v, 32'h0);
`endif
      mon_data = mon_data ^ 7'h01;
      tick();
      rd(6'h04, v);
`ifdef PRISM_LOG_MASK_EN
      check("t6_entry", {24'b0, v[31:24]}, 32'h9A);
`else
      check("t6_entry", {24'b0, v[31:24]}, 32'h9B);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
